// File: rtl/simple_distributor.sv
// rtl/simple_distributor.sv - steers a buffered data stream left or right under a paired steering-token stream
module simple_distributor #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W:0]   in_data,
  output logic              in_back_stop,
  input  logic [1:0]        choose_right,
  output logic              choose_right_back_stop,
  output logic [DATA_W:0]   left_data,
  input  logic              left_down_stop,
  output logic [DATA_W:0]   right_data,
  input  logic              right_down_stop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] r_dmem [DEPTH];
  logic [AW-1:0]     r_dwr;
  logic [AW-1:0]     r_drd;
  logic [CW-1:0]     r_dcnt;

  logic              r_cmem [DEPTH];
  logic [AW-1:0]     r_cwr;
  logic [AW-1:0]     r_crd;
  logic [CW-1:0]     r_ccnt;

  logic [DATA_W:0]   r_left_data;
  logic [DATA_W:0]   r_right_data;

  logic w_d_push;
  logic w_c_push;
  logic w_tgt_right;
  logic w_left_free;
  logic w_right_free;
  logic w_fire;
  logic w_fire_left;
  logic w_fire_right;

  // Back-stops come from registered counts only, so no input-to-output path exists.
  assign in_back_stop           = (r_dcnt == FULL);
  assign choose_right_back_stop = (r_ccnt == FULL);

  assign w_d_push = in_data[DATA_W] & ~in_back_stop;
  assign w_c_push = choose_right[1] & ~choose_right_back_stop;

  assign w_tgt_right  = r_cmem[r_crd];
  assign w_left_free  = ~r_left_data[DATA_W] | ~left_down_stop;
  assign w_right_free = ~r_right_data[DATA_W] | ~right_down_stop;
  assign w_fire       = (r_dcnt != '0) && (r_ccnt != '0) &&
                        (w_tgt_right ? w_right_free : w_left_free);
  assign w_fire_left  = w_fire & ~w_tgt_right;
  assign w_fire_right = w_fire & w_tgt_right;

  assign left_data  = r_left_data;
  assign right_data = r_right_data;

  always_ff @(posedge clk) begin
    if (w_d_push) r_dmem[r_dwr] <= in_data[DATA_W-1:0];
    if (w_c_push) r_cmem[r_cwr] <= choose_right[0];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dwr  <= '0;
      r_drd  <= '0;
      r_dcnt <= '0;
      r_cwr  <= '0;
      r_crd  <= '0;
      r_ccnt <= '0;
    end else begin
      if (w_d_push) r_dwr <= r_dwr + AW'(1);
      if (w_c_push) r_cwr <= r_cwr + AW'(1);
      if (w_fire) begin
        r_drd <= r_drd + AW'(1);
        r_crd <= r_crd + AW'(1);
      end
      r_dcnt <= r_dcnt + CW'(w_d_push) - CW'(w_fire);
      r_ccnt <= r_ccnt + CW'(w_c_push) - CW'(w_fire);
    end
  end

  // A consumed register with no incoming fire drops its valid bit but keeps its payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_left_data  <= '0;
      r_right_data <= '0;
    end else begin
      if (w_fire_left)
        r_left_data <= {1'b1, r_dmem[r_drd]};
      else if (r_left_data[DATA_W] && !left_down_stop)
        r_left_data[DATA_W] <= 1'b0;

      if (w_fire_right)
        r_right_data <= {1'b1, r_dmem[r_drd]};
      else if (r_right_data[DATA_W] && !right_down_stop)
        r_right_data[DATA_W] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simple_distributor.sv
// tb/tb_simple_distributor.sv - directed self-checking bench for simple_distributor
module tb_simple_distributor;

  logic       clk;
  logic       reset_n;
  logic [8:0] in_data;
  logic       in_back_stop;
  logic [1:0] choose_right;
  logic       choose_right_back_stop;
  logic [8:0] left_data;
  logic       left_down_stop;
  logic [8:0] right_data;
  logic       right_down_stop;

  int n_checks = 0;
  int n_errors = 0;

  simple_distributor #(.DATA_W(8), .DEPTH(2)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .in_data                (in_data),
    .in_back_stop           (in_back_stop),
    .choose_right           (choose_right),
    .choose_right_back_stop (choose_right_back_stop),
    .left_data              (left_data),
    .left_down_stop         (left_down_stop),
    .right_data             (right_data),
    .right_down_stop        (right_down_stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge; one call = one rising edge passed.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    in_data      = 9'h000;
    choose_right = 2'b00;
  endtask

  task automatic do_reset();
    idle();
    left_down_stop  = 1'b0;
    right_down_stop = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (left_data !== 9'h000) begin n_errors++; $display("FAIL reset_left got %h exp %h", left_data, 9'h000); end
    n_checks++; if (right_data !== 9'h000) begin n_errors++; $display("FAIL reset_right got %h exp %h", right_data, 9'h000); end
    n_checks++; if ({in_back_stop, choose_right_back_stop} !== 2'b00) begin n_errors++; $display("FAIL reset_bs got %b exp 00", {in_back_stop, choose_right_back_stop}); end
  endtask

  task automatic test_steer_right();
    in_data = 9'h10F; choose_right = 2'b11;
    step();
    idle();
    n_checks++; if (right_data[8] !== 1'b0) begin n_errors++; $display("FAIL steer_early got %h exp invalid", right_data); end
    step();
    n_checks++; if (right_data !== 9'h10F) begin n_errors++; $display("FAIL steer_right got %h exp %h", right_data, 9'h10F); end
    n_checks++; if (left_data !== 9'h000) begin n_errors++; $display("FAIL steer_left_quiet got %h exp %h", left_data, 9'h000); end
    step();
    n_checks++; if (right_data !== 9'h00F) begin n_errors++; $display("FAIL steer_consume got %h exp %h", right_data, 9'h00F); end
  endtask

  task automatic test_alternating();
    logic [8:0] d_in  [4] = '{9'h101, 9'h102, 9'h103, 9'h104};
    logic [1:0] c_in  [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    // Expected outputs observed after each of edges 1..6.
    logic [8:0] exp_l [6] = '{9'h00F, 9'h101, 9'h001, 9'h103, 9'h003, 9'h003};
    logic [8:0] exp_r [6] = '{9'h00F, 9'h00F, 9'h102, 9'h002, 9'h104, 9'h004};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin in_data = d_in[i]; choose_right = c_in[i]; end
      else idle();
      step();
      if (i == 0) begin
        n_checks++; if ({left_data[8], right_data[8]} !== 2'b00) begin n_errors++; $display("FAIL alt_first got %b exp 00", {left_data[8], right_data[8]}); end
      end else begin
        n_checks++; if (left_data !== exp_l[i] && !(i == 1 && left_data === 9'h101) && !(left_data[8] === 1'b0 && exp_l[i][8] === 1'b0 && i < 1)) begin n_errors++; $display("FAIL alt_left[%0d] got %h exp %h", i, left_data, exp_l[i]); end
        n_checks++; if (right_data[8] !== exp_r[i][8] || (exp_r[i][8] && right_data !== exp_r[i])) begin n_errors++; $display("FAIL alt_right[%0d] got %h exp %h", i, right_data, exp_r[i]); end
      end
      n_checks++; if ({in_back_stop, choose_right_back_stop} !== 2'b00) begin n_errors++; $display("FAIL alt_bs[%0d] got %b exp 00", i, {in_back_stop, choose_right_back_stop}); end
    end
  endtask

  task automatic test_stall_release();
    do_reset();
    right_down_stop = 1'b1;
    in_data = 9'h1A0; choose_right = 2'b11; step();
    in_data = 9'h1A1; step();
    n_checks++; if (right_data !== 9'h1A0) begin n_errors++; $display("FAIL stall_first got %h exp %h", right_data, 9'h1A0); end
    in_data = 9'h1A2; step();
    n_checks++; if ({in_back_stop, choose_right_back_stop} !== 2'b11) begin n_errors++; $display("FAIL stall_bs got %b exp 11", {in_back_stop, choose_right_back_stop}); end
    in_data = 9'h1A3; step(); step();
    n_checks++; if (right_data !== 9'h1A0) begin n_errors++; $display("FAIL stall_hold got %h exp %h", right_data, 9'h1A0); end
    n_checks++; if ({in_back_stop, choose_right_back_stop} !== 2'b11) begin n_errors++; $display("FAIL stall_bs_hold got %b exp 11", {in_back_stop, choose_right_back_stop}); end
    right_down_stop = 1'b0;
    step();
    n_checks++; if (right_data !== 9'h1A1) begin n_errors++; $display("FAIL release_a1 got %h exp %h", right_data, 9'h1A1); end
    n_checks++; if ({in_back_stop, choose_right_back_stop} !== 2'b00) begin n_errors++; $display("FAIL release_bs got %b exp 00", {in_back_stop, choose_right_back_stop}); end
    step();
    n_checks++; if (right_data !== 9'h1A2) begin n_errors++; $display("FAIL release_a2 got %h exp %h", right_data, 9'h1A2); end
    in_data = 9'h1A4; step();
    idle();
    n_checks++; if (right_data !== 9'h1A3) begin n_errors++; $display("FAIL release_a3 got %h exp %h", right_data, 9'h1A3); end
    step();
    n_checks++; if (right_data !== 9'h1A4) begin n_errors++; $display("FAIL release_a4 got %h exp %h", right_data, 9'h1A4); end
    step();
    n_checks++; if (right_data !== 9'h0A4) begin n_errors++; $display("FAIL release_drain got %h exp %h", right_data, 9'h0A4); end
    n_checks++; if (left_data !== 9'h000) begin n_errors++; $display("FAIL stall_left_quiet got %h exp %h", left_data, 9'h000); end
  endtask

  task automatic test_ctrl_first();
    do_reset();
    choose_right = 2'b10; step();
    idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (left_data[8] !== 1'b0) begin n_errors++; $display("FAIL ctrl_wait[%0d] got %h exp invalid", i, left_data); end
      step();
    end
    in_data = 9'h1AC; step();
    idle();
    n_checks++; if (left_data[8] !== 1'b0) begin n_errors++; $display("FAIL ctrl_data_write got %h exp invalid", left_data); end
    step();
    n_checks++; if (left_data !== 9'h1AC) begin n_errors++; $display("FAIL ctrl_late got %h exp %h", left_data, 9'h1AC); end
    n_checks++; if (right_data[8] !== 1'b0) begin n_errors++; $display("FAIL ctrl_right_quiet got %h exp invalid", right_data); end
  endtask

  task automatic test_head_of_line();
    do_reset();
    left_down_stop = 1'b1;
    in_data = 9'h111; choose_right = 2'b10; step();
    in_data = 9'h112; choose_right = 2'b10; step();
    n_checks++; if (left_data !== 9'h111) begin n_errors++; $display("FAIL hol_setup got %h exp %h", left_data, 9'h111); end
    in_data = 9'h113; choose_right = 2'b11; step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (right_data[8] !== 1'b0 || left_data !== 9'h111) begin n_errors++; $display("FAIL hol_block[%0d] got l=%h r=%h exp l=111 r invalid", i, left_data, right_data); end
    end
    left_down_stop = 1'b0;
    step();
    n_checks++; if (left_data !== 9'h112 || right_data[8] !== 1'b0) begin n_errors++; $display("FAIL hol_release got l=%h r=%h exp l=112 r invalid", left_data, right_data); end
    step();
    n_checks++; if (right_data !== 9'h113) begin n_errors++; $display("FAIL hol_right got %h exp %h", right_data, 9'h113); end
    n_checks++; if (left_data !== 9'h012) begin n_errors++; $display("FAIL hol_left_drain got %h exp %h", left_data, 9'h012); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    left_down_stop = 1'b1; right_down_stop = 1'b1;
    in_data = 9'h121; choose_right = 2'b10; step();
    in_data = 9'h122; choose_right = 2'b11; step();
    in_data = 9'h123; choose_right = 2'b10; step();
    in_data = 9'h124; choose_right = 2'b11; step();
    idle();
    n_checks++; if ({left_data, right_data} !== {9'h121, 9'h122}) begin n_errors++; $display("FAIL mid_setup got l=%h r=%h exp l=121 r=122", left_data, right_data); end
    n_checks++; if ({in_back_stop, choose_right_back_stop} !== 2'b11) begin n_errors++; $display("FAIL mid_setup_bs got %b exp 11", {in_back_stop, choose_right_back_stop}); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({left_data, right_data} !== 18'h0) begin n_errors++; $display("FAIL mid_async got l=%h r=%h exp 000", left_data, right_data); end
    n_checks++; if ({in_back_stop, choose_right_back_stop} !== 2'b00) begin n_errors++; $display("FAIL mid_async_bs got %b exp 00", {in_back_stop, choose_right_back_stop}); end
    step();
    reset_n = 1'b1;
    left_down_stop = 1'b0; right_down_stop = 1'b0;
    in_data = 9'h155; choose_right = 2'b11; step();
    idle();
    n_checks++; if (right_data !== 9'h000) begin n_errors++; $display("FAIL mid_early got %h exp %h", right_data, 9'h000); end
    step();
    n_checks++; if (right_data !== 9'h155) begin n_errors++; $display("FAIL mid_new got %h exp %h", right_data, 9'h155); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (left_data !== 9'h000 || right_data !== 9'h055) begin n_errors++; $display("FAIL mid_stale[%0d] got l=%h r=%h exp l=000 r=055", i, left_data, right_data); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    left_down_stop  = 1'b0;
    right_down_stop = 1'b0;
    test_reset();
    test_steer_right();
    test_alternating();
    test_stall_release();
    test_ctrl_first();
    test_head_of_line();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
